// File: rtl/fpga_io_arbiter.sv
// Two-core round-robin arbiter for the FPGA general-purpose output/input registers.
// Each granted access runs IDLE -> SERVE -> ACK and answers with a one-cycle ack.
module fpga_io_arbiter #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [2:0]      a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_be,
  output logic            a_ack,
  output logic            a_err,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [2:0]      b_addr,
  input  logic [DW-1:0]   b_wdata,
  input  logic [DW/8-1:0] b_be,
  output logic            b_ack,
  output logic            b_err,
  output logic [DW-1:0]   b_rdata,
  output logic [DW-1:0]   fpga_o0,
  output logic [DW-1:0]   fpga_o1,
  output logic [DW-1:0]   fpga_o2,
  input  logic [DW-1:0]   fpga_i0,
  input  logic [DW-1:0]   fpga_i1,
  input  logic [DW-1:0]   fpga_i2,
  output logic            busy
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic rr_q, rr_d;
  logic gnt_q, gnt_d;

  logic [2:0][DW-1:0] o_q, o_d;

  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          a_err_q, a_err_d;
  logic          b_err_q, b_err_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic          s_we;
  logic [2:0]    s_addr;
  logic [DW-1:0] s_wdata;
  logic [BW-1:0] s_be;

  logic          s_out;
  logic          s_in;
  logic [DW-1:0] s_oword;
  logic [DW-1:0] s_iword;
  logic [DW-1:0] s_rd;
  logic          s_err;

  // Fields of the granted requester; they are held stable until ack.
  always_comb begin
    s_we    = gnt_q ? b_we    : a_we;
    s_addr  = gnt_q ? b_addr  : a_addr;
    s_wdata = gnt_q ? b_wdata : a_wdata;
    s_be    = gnt_q ? b_be    : a_be;
  end

  always_comb begin
    s_out   = !s_addr[2] && (s_addr[1:0] != 2'd3);
    s_in    = s_addr[2] && (s_addr[1:0] != 2'd3);
    s_oword = '0;
    s_iword = '0;
    unique case (s_addr[1:0])
      2'd0: begin
        s_oword = o_q[0];
        s_iword = fpga_i0;
      end
      2'd1: begin
        s_oword = o_q[1];
        s_iword = fpga_i1;
      end
      2'd2: begin
        s_oword = o_q[2];
        s_iword = fpga_i2;
      end
      default: begin
        s_oword = '0;
        s_iword = '0;
      end
    endcase
  end

  always_comb begin
    s_rd  = '0;
    s_err = 1'b0;
    unique case (1'b1)
      s_out: begin
        if (!s_we) s_rd = s_oword;
      end
      s_in: begin
        if (s_we) s_err = 1'b1;
        else      s_rd  = s_iword;
      end
      default: begin
        s_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    o_d       = o_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_d   = (a_req && b_req) ? rr_q : b_req;
          rr_d    = ~gnt_d;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (s_out && s_we) begin
          for (int k = 0; k < 3; k++) begin
            if (s_addr[1:0] == 2'(k)) begin
              for (int j = 0; j < BW; j++) begin
                if (s_be[j]) o_d[k][8*j +: 8] = s_wdata[8*j +: 8];
              end
            end
          end
        end
        if (gnt_q) begin
          b_ack_d   = 1'b1;
          b_err_d   = s_err;
          b_rdata_d = s_rd;
        end else begin
          a_ack_d   = 1'b1;
          a_err_d   = s_err;
          a_rdata_d = s_rd;
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      o_q       <= {3{{DW{1'b1}}}};
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      o_q       <= o_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_err   = a_err_q;
  assign b_err   = b_err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign fpga_o0 = o_q[0];
  assign fpga_o1 = o_q[1];
  assign fpga_o2 = o_q[2];
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fpga_io_arbiter.sv
// Directed bench for fpga_io_arbiter: reset, byte writes, arbitration,
// input reads, error responses and back-to-back timing.
module tb_fpga_io_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] fpga_o0, fpga_o1, fpga_o2;
  logic [31:0] fpga_i0, fpga_i1, fpga_i2;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fpga_io_arbiter #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .fpga_o0(fpga_o0), .fpga_o1(fpga_o1), .fpga_o2(fpga_o2),
    .fpga_i0(fpga_i0), .fpga_i1(fpga_i1), .fpga_i2(fpga_i2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single-requester access; caller is 1 time unit after a rising edge.
  task automatic access(input bit who, input bit we, input logic [2:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input string tag);
    if (!who) begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    end else begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    end
    tick();
    chk({tag, ".busy_serve"}, {31'd0, busy}, 32'd1);
    chk({tag, ".ack_serve"}, {31'd0, who ? b_ack : a_ack}, 32'd0);
    tick();
    chk({tag, ".ack"}, {31'd0, who ? b_ack : a_ack}, 32'd1);
    chk({tag, ".other_ack"}, {31'd0, who ? a_ack : b_ack}, 32'd0);
    chk({tag, ".err"}, {31'd0, who ? b_err : a_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, who ? b_rdata : a_rdata, exp_rd);
    if (!who) a_req = 0;
    else      b_req = 0;
    tick();
    chk({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ".ack_idle"}, {31'd0, who ? b_ack : a_ack}, 32'd0);
  endtask

  initial begin
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    fpga_i0 = 32'h0000_1111;
    fpga_i1 = 32'h0000_2222;
    fpga_i2 = 32'h0000_3333;

    #12;
    chk("rst.o0", fpga_o0, 32'hFFFF_FFFF);
    chk("rst.o1", fpga_o1, 32'hFFFF_FFFF);
    chk("rst.o2", fpga_o2, 32'hFFFF_FFFF);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst.rdata", a_rdata | b_rdata, 32'd0);
    rst_n = 1;
    tick();

    // Byte-enabled write: only lanes 0 and 2 change.
    access(0, 1, 3'd1, 32'h1234_5678, 4'b0101, 32'd0, 0, "bw.wr");
    chk("bw.o1", fpga_o1, 32'hFF34_FF78);
    access(0, 0, 3'd1, 32'd0, 4'd0, 32'hFF34_FF78, 0, "bw.rd");

    // Reset in the middle of SERVE drops the write and the ack.
    a_req = 1; a_we = 1; a_addr = 3'd0; a_wdata = 32'h0; a_be = 4'hF;
    tick();
    chk("mrst.busy_before", {31'd0, busy}, 32'd1);
    #3 rst_n = 0;
    #1;
    chk("mrst.o0", fpga_o0, 32'hFFFF_FFFF);
    chk("mrst.o1", fpga_o1, 32'hFFFF_FFFF);
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.ack", {30'd0, a_ack, b_ack}, 32'd0);
    chk("mrst.err", {30'd0, a_err, b_err}, 32'd0);
    chk("mrst.a_rdata", a_rdata, 32'd0);
    a_req = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mrst.no_ack", {30'd0, a_ack, b_ack}, 32'd0);
    end
    chk("mrst.o0_after", fpga_o0, 32'hFFFF_FFFF);

    // Simultaneous requests after reset: A first, then B.
    a_req = 1; a_we = 1; a_addr = 3'd0; a_wdata = 32'hAAAA_AAAA; a_be = 4'hF;
    b_req = 1; b_we = 1; b_addr = 3'd0; b_wdata = 32'hBBBB_BBBB; b_be = 4'hF;
    tick();
    tick();
    chk("sim1.a_ack", {31'd0, a_ack}, 32'd1);
    chk("sim1.b_ack", {31'd0, b_ack}, 32'd0);
    chk("sim1.o0_a", fpga_o0, 32'hAAAA_AAAA);
    a_req = 0;
    tick();
    tick();
    tick();
    chk("sim1.b_ack2", {31'd0, b_ack}, 32'd1);
    chk("sim1.a_ack2", {31'd0, a_ack}, 32'd0);
    chk("sim1.o0_b", fpga_o0, 32'hBBBB_BBBB);
    b_req = 0;
    tick();

    // Second pair: rr points back to A.
    a_req = 1; a_we = 1; a_addr = 3'd2; a_wdata = 32'h1111_1111; a_be = 4'hF;
    b_req = 1; b_we = 1; b_addr = 3'd2; b_wdata = 32'h2222_2222; b_be = 4'h3;
    tick();
    tick();
    chk("sim2.a_ack", {31'd0, a_ack}, 32'd1);
    chk("sim2.b_ack", {31'd0, b_ack}, 32'd0);
    chk("sim2.o2_a", fpga_o2, 32'h1111_1111);
    a_req = 0;
    tick();
    tick();
    tick();
    chk("sim2.b_ack2", {31'd0, b_ack}, 32'd1);
    chk("sim2.o2_b", fpga_o2, 32'h1111_2222);
    b_req = 0;
    tick();

    // Input read by B; a_ack checked 0 inside the access.
    fpga_i2 = 32'hDEAD_BEEF;
    access(1, 0, 3'd6, 32'd0, 4'd0, 32'hDEAD_BEEF, 0, "inrd");

    // Back-to-back reads of addr 0 with req held.
    a_req = 1; a_we = 0; a_addr = 3'd0; a_be = 4'd0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("b2b.ack%0d", c), {31'd0, a_ack},
          {31'd0, (c == 2 || c == 5 || c == 8)});
      chk($sformatf("b2b.busy%0d", c), {31'd0, busy},
          {31'd0, !(c == 3 || c == 6 || c == 9)});
      if (c == 2) chk("b2b.rdata", a_rdata, 32'hBBBB_BBBB);
      if (c == 8) a_req = 0;
    end

    // Error responses.
    access(0, 0, 3'd3, 32'd0, 4'd0, 32'd0, 1, "err.rd3");
    access(0, 1, 3'd5, 32'hCAFE_F00D, 4'hF, 32'd0, 1, "err.wr5");
    chk("err.o0", fpga_o0, 32'hBBBB_BBBB);
    chk("err.o1", fpga_o1, 32'hFFFF_FFFF);
    chk("err.o2", fpga_o2, 32'h1111_2222);
    access(1, 1, 3'd7, 32'h0, 4'hF, 32'd0, 1, "err.wr7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
